// File: rtl/micro_sequencer.sv
// Micro-address sequencer for the control-store ROM.
// Also owns the run/halt state, illegal-opcode trap and dispatch count.
module micro_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic [4:0]       next_addr,
   input  logic             dispatch,
   input  logic [4:0]       opcode,
   input  logic             z,
   output logic [4:0]       addr,
   output logic             running,
   output logic             halted,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   localparam logic [4:0] FETCH1 = 5'd0;
   localparam logic [4:0] NOP    = 5'd31;

   state_t     state;
   logic [4:0] map_addr;
   logic       legal;
   logic       cnt_max;

   assign cnt_max = &instr_cnt;
   assign running = (state == RUN);
   assign halted  = (state == HALT);

   always_comb begin
      legal    = 1'b1;
      map_addr = NOP;
      case (opcode)
         5'd0:    map_addr = 5'd2;
         5'd1:    map_addr = 5'd3;
         5'd2:    map_addr = 5'd4;
         5'd3:    map_addr = 5'd5;
         5'd4:    map_addr = z ? 5'd11 : 5'd9;
         5'd5:    map_addr = 5'd12;
         5'd6:    map_addr = 5'd13;
         5'd7:    map_addr = 5'd14;
         5'd8:    map_addr = 5'd15;
         5'd9:    map_addr = 5'd16;
         5'd10:   map_addr = 5'd17;
         5'd11:   map_addr = 5'd18;
         5'd12:   map_addr = 5'd19;
         5'd13:   map_addr = 5'd21;
         5'd14:   map_addr = 5'd24;
         5'd15:   map_addr = 5'd25;
         5'd16:   map_addr = 5'd26;
         default: legal    = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= NOP;
         done      <= 1'b0;
         illegal   <= 1'b0;
         instr_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            RUN: begin
               if (!stall) begin
                  if (dispatch) begin
                     if (!cnt_max)
                        instr_cnt <= instr_cnt + 1'b1;
                     if (legal) begin
                        addr <= map_addr;
                     end else begin
                        addr    <= NOP;
                        illegal <= 1'b1;
                        state   <= HALT;
                        done    <= 1'b1;
                     end
                  end else if (next_addr != NOP) begin
                     addr <= next_addr;
                  end else begin
                     addr  <= NOP;
                     state <= HALT;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               // IDLE and HALT both park on NOP and restart identically
               addr <= NOP;
               if (start) begin
                  state     <= RUN;
                  addr      <= FETCH1;
                  instr_cnt <= '0;
                  illegal   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: behavioural model plus per-cycle compare.
// Directed flows pin the model with literal addresses; random traffic follows.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic [4:0]  next_addr = 5'd0;
   logic        dispatch = 1'b0;
   logic [4:0]  opcode = 5'd0;
   logic        z = 1'b0;
   logic [4:0]  addr;
   logic        running;
   logic        halted;
   logic        done;
   logic        illegal;
   logic [15:0] instr_cnt;

   micro_sequencer #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .next_addr (next_addr),
      .dispatch  (dispatch),
      .opcode    (opcode),
      .z         (z),
      .addr      (addr),
      .running   (running),
      .halted    (halted),
      .done      (done),
      .illegal   (illegal),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // model: mode 0=idle 1=run 2=halt
   int m_mode, m_addr, m_cnt, m_done, m_ill;
   int tab[17] = '{2, 3, 4, 5, 0, 12, 13, 14, 15, 16, 17, 18, 19, 21, 24, 25, 26};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_addr = 31;
      m_cnt  = 0;
      m_done = 0;
      m_ill  = 0;
   endtask

   task automatic model_step(input bit st, input bit stl, input int na,
                             input bit dp, input int op, input bit zz);
      m_done = 0;
      if (m_mode != 1) begin
         if (st) begin
            m_mode = 1;
            m_addr = 0;
            m_cnt  = 0;
            m_ill  = 0;
         end
      end else if (!stl) begin
         if (dp) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (op == 4) m_addr = zz ? 11 : 9;
            else if (op <= 16) m_addr = tab[op];
            else begin
               m_addr = 31;
               m_ill  = 1;
               m_mode = 2;
               m_done = 1;
            end
         end else if (na != 31) begin
            m_addr = na;
         end else begin
            m_addr = 31;
            m_mode = 2;
            m_done = 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("addr", int'(addr), m_addr);
         chk("running", int'(running), int'(m_mode == 1));
         chk("halted", int'(halted), int'(m_mode == 2));
         chk("done", int'(done), m_done);
         chk("illegal", int'(illegal), m_ill);
         chk("instr_cnt", int'(instr_cnt), m_cnt);
      end
   end

   task automatic step(input bit st, input bit stl, input logic [4:0] na,
                       input bit dp, input logic [4:0] op, input bit zz);
      start     = st;
      stall     = stl;
      next_addr = na;
      dispatch  = dp;
      opcode    = op;
      z         = zz;
      @(posedge clk);
      model_step(st, stl, int'(na), dp, int'(op), zz);
      @(negedge clk);
   endtask

   // small control-store ROM driven from the model's address
   task automatic rom_step(input logic [4:0] op, input bit zz, input bit stl);
      logic [4:0] na;
      bit dp;
      dp = (m_addr == 1);
      case (m_addr)
         0:       na = 5'd1;
         9:       na = 5'd10;
         19:      na = 5'd20;
         26:      na = 5'd31;
         default: na = 5'd0;
      endcase
      step(1'b0, stl, na, dp, op, zz);
   endtask

   task automatic go();
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      model_reset();
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("lit_reset_addr", int'(addr), 31);
      chk("lit_reset_cnt", int'(instr_cnt), 0);
      rst_n = 1'b1;

      // ADD flow: 31,0,1,16,0
      go();
      chk("lit_add_a0", int'(addr), 0);
      rom_step(5'd9, 1'b0, 1'b0);
      chk("lit_add_a1", int'(addr), 1);
      rom_step(5'd9, 1'b0, 1'b0);
      chk("lit_add_a16", int'(addr), 16);
      chk("lit_add_cnt", int'(instr_cnt), 1);
      rom_step(5'd9, 1'b0, 1'b0);
      chk("lit_add_back0", int'(addr), 0);

      // JMPNZ z=0: 1,9,10,0
      rom_step(5'd4, 1'b0, 1'b0);
      rom_step(5'd4, 1'b0, 1'b0);
      chk("lit_jnz0_9", int'(addr), 9);
      rom_step(5'd4, 1'b0, 1'b0);
      chk("lit_jnz0_10", int'(addr), 10);
      rom_step(5'd4, 1'b0, 1'b0);
      chk("lit_jnz0_0", int'(addr), 0);

      // JMPNZ z=1: 1,11,0
      rom_step(5'd4, 1'b1, 1'b0);
      rom_step(5'd4, 1'b1, 1'b0);
      chk("lit_jnz1_11", int'(addr), 11);
      chk("lit_jnz1_cnt", int'(instr_cnt), 3);
      rom_step(5'd4, 1'b1, 1'b0);
      chk("lit_jnz1_0", int'(addr), 0);

      // LOAD with a 3-cycle stall at 19
      rom_step(5'd12, 1'b0, 1'b0);
      rom_step(5'd12, 1'b0, 1'b0);
      chk("lit_load_19", int'(addr), 19);
      for (int i = 0; i < 3; i++) begin
         rom_step(5'd12, 1'b0, 1'b1);
         chk("lit_load_stall", int'(addr), 19);
      end
      rom_step(5'd12, 1'b0, 1'b0);
      chk("lit_load_20", int'(addr), 20);
      rom_step(5'd12, 1'b0, 1'b0);
      chk("lit_load_0", int'(addr), 0);

      // OPEND: 1,26,31 with single done pulse
      rom_step(5'd16, 1'b0, 1'b0);
      rom_step(5'd16, 1'b0, 1'b0);
      chk("lit_opend_26", int'(addr), 26);
      rom_step(5'd16, 1'b0, 1'b0);
      chk("lit_opend_31", int'(addr), 31);
      chk("lit_opend_done", int'(done), 1);
      chk("lit_opend_halted", int'(halted), 1);
      rom_step(5'd16, 1'b0, 1'b0);
      chk("lit_opend_done_low", int'(done), 0);
      step(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("lit_restart_addr", int'(addr), 0);
      chk("lit_restart_cnt", int'(instr_cnt), 0);

      // illegal opcode 20
      rom_step(5'd20, 1'b0, 1'b0);
      rom_step(5'd20, 1'b0, 1'b0);
      chk("lit_ill_addr", int'(addr), 31);
      chk("lit_ill_flag", int'(illegal), 1);
      chk("lit_ill_done", int'(done), 1);
      chk("lit_ill_cnt", int'(instr_cnt), 1);
      rom_step(5'd20, 1'b0, 1'b0);
      chk("lit_ill_sticky", int'(illegal), 1);
      go();
      chk("lit_ill_cleared", int'(illegal), 0);

      // async reset mid-RUN
      rom_step(5'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_async_addr", int'(addr), 31);
      chk("lit_async_running", int'(running), 0);
      chk("lit_async_cnt", int'(instr_cnt), 0);
      model_reset();
      #1 rst_n = 1'b1;

      // saturate the counter by dispatching every cycle
      go();
      for (int i = 0; i < 65540; i++)
         step(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0);
      chk("lit_sat_cnt", int'(instr_cnt), 65535);
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'd25, 1'b0);
      chk("lit_sat_ill_cnt", int'(instr_cnt), 65535);
      chk("lit_sat_ill_halt", int'(halted), 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 rst_n = 1'b1;
         end
         step(($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30)),
              ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 20)),
              1'($urandom_range(0, 1)));
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
